// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC core branch-resolution logic.
package wisc_pkg;

  // Branch condition codes carried in the B/BR instruction.
  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_N = 0;

  typedef enum logic [0:0] {IDLE, HOLD} br_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  // Increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage conditional branch resolution: flag register, condition check,
// one-cycle flag hazard stall, PC select / IF flush and debug counters.
module branch_resolve_ctrl
  import wisc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ext,
  input  logic             ex_valid,
  input  logic [2:0]       ex_flag_we,
  input  logic [2:0]       ex_flags,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [2:0]       id_ccc,
  input  logic             id_flush,
  output logic [2:0]       flags_q,
  output logic             stall_id,
  output logic             take_branch,
  output logic             pc_sel,
  output logic             flush_if,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);

  function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n, res;
    z = f[FLG_Z];
    v = f[FLG_V];
    n = f[FLG_N];
    case (ccc)
      CC_NE:   res = !z;
      CC_EQ:   res = z;
      CC_GT:   res = !z && !n;
      CC_LT:   res = n;
      CC_GE:   res = z || (!z && !n);
      CC_LE:   res = n || z;
      CC_OVFL: res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  br_state_e state_q, state_d;
  logic      br_req, hz, cond, resolve;

  assign br_req = id_valid && id_is_branch && !id_flush;
  // Unconditional branches ignore flags, so an in-flight writer is harmless.
  assign hz     = ex_valid && (|ex_flag_we) && (id_ccc != CC_UNCOND);
  assign cond   = cond_eval(id_ccc, flags_q);

  // Per-bit flag writes from the EX instruction; frozen by stall_ext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (ex_valid && !stall_ext) begin
      for (int i = 0; i < 3; i++) begin
        if (ex_flag_we[i]) flags_q[i] <= ex_flags[i];
      end
    end
  end

  // Next state, stall request and resolution decision.
  always_comb begin
    state_d  = state_q;
    stall_id = 1'b0;
    resolve  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_req) begin
          if (hz) begin
            stall_id = 1'b1;
            state_d  = HOLD;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      HOLD: begin
        // Writer has left EX, flags_q is current; a flushed branch just drops.
        state_d = IDLE;
        resolve = br_req;
      end
      default: state_d = IDLE;
    endcase
    if (stall_ext) begin
      state_d = state_q;
      resolve = 1'b0;
    end
    // Keep every output quiet while reset is held, even with a live ID branch.
    if (!rst_n) begin
      stall_id = 1'b0;
      resolve  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign take_branch = resolve && cond;
  assign pc_sel      = take_branch;
  assign flush_if    = take_branch;

  sat_counter #(
    .Width(CNT_W)
  ) u_br_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (resolve),
    .count(br_count)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_taken_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (take_branch),
    .count(br_taken_count)
  );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a scoreboard for control outputs.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_ext, ex_valid, id_valid, id_is_branch, id_flush;
  logic [2:0]  ex_flag_we, ex_flags, id_ccc;
  logic [2:0]  flags_q;
  logic        stall_id, take_branch, pc_sel, flush_if;
  logic [15:0] br_count, br_taken_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    logic  stall;
    logic  take;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_ext     (stall_ext),
    .ex_valid      (ex_valid),
    .ex_flag_we    (ex_flag_we),
    .ex_flags      (ex_flags),
    .id_valid      (id_valid),
    .id_is_branch  (id_is_branch),
    .id_ccc        (id_ccc),
    .id_flush      (id_flush),
    .flags_q       (flags_q),
    .stall_id      (stall_id),
    .take_branch   (take_branch),
    .pc_sel        (pc_sel),
    .flush_if      (flush_if),
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected control outputs, compare
  // them mid-cycle, then advance past the rising edge.
  task automatic step(input string tag, input logic idv, input logic isb, input logic [2:0] ccc,
                      input logic fl, input logic exv, input logic [2:0] we,
                      input logic [2:0] f, input logic stx, input logic e_stall,
                      input logic e_take);
    exp_t e;
    id_valid     = idv;
    id_is_branch = isb;
    id_ccc       = ccc;
    id_flush     = fl;
    ex_valid     = exv;
    ex_flag_we   = we;
    ex_flags     = f;
    stall_ext    = stx;
    e.tag   = tag;
    e.stall = e_stall;
    e.take  = e_take;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".stall_id"}, 32'(stall_id), 32'(e.stall));
      chk({e.tag, ".take"}, 32'(take_branch), 32'(e.take));
      chk({e.tag, ".pc_sel"}, 32'(pc_sel), 32'(e.take));
      chk({e.tag, ".flush_if"}, 32'(flush_if), 32'(e.take));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] f, input int unsigned bc,
                           input int unsigned tc);
    chk({tag, ".flags"}, 32'(flags_q), 32'(f));
    chk({tag, ".br_count"}, 32'(br_count), bc);
    chk({tag, ".taken_count"}, 32'(br_taken_count), tc);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_ext = 0; ex_valid = 0; ex_flag_we = 0; ex_flags = 0;
    id_valid = 0; id_is_branch = 0; id_ccc = 0; id_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall_id", 32'(stall_id), 0);
    chk("rst.take", 32'(take_branch), 0);
    chk_state("rst", 3'b000, 0, 0);
    rst_n = 1'b1;

    // NE with Z=0: taken with no stall.
    step("ne_taken", 1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("ne_taken", 3'b000, 1, 1);
    // EQ behind a full flag writer: one stall, then taken on Z=1.
    step("eq_hz", 1, 1, 3'b001, 0, 1, 3'b111, 3'b100, 0, 1, 0);
    chk_state("eq_hz", 3'b100, 1, 1);
    step("eq_hold", 1, 1, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("eq_hold", 3'b100, 2, 2);
    // Non-branch cycle writing flags to 001.
    step("flag_ld", 0, 0, 3'b000, 0, 1, 3'b111, 3'b001, 0, 0, 0);
    chk_state("flag_ld", 3'b001, 2, 2);
    // Partial mask sets V only: 001 -> 011; OVFL then taken.
    step("ovfl_hz", 1, 1, 3'b110, 0, 1, 3'b010, 3'b010, 0, 1, 0);
    chk_state("ovfl_hz", 3'b011, 2, 2);
    step("ovfl_hold", 1, 1, 3'b110, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("ovfl_hold", 3'b011, 3, 2 + 1);
    // GT with N=1: not taken, counted as resolved.
    step("gt_nt", 1, 1, 3'b010, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    chk_state("gt_nt", 3'b011, 4, 3);
    // Unconditional with writer in EX: no stall, taken.
    step("uncond", 1, 1, 3'b111, 0, 1, 3'b111, 3'b000, 0, 0, 1);
    chk_state("uncond", 3'b000, 5, 4);
    // LT enters HOLD, then three external stall cycles with a writer present.
    step("lt_hz", 1, 1, 3'b011, 0, 1, 3'b001, 3'b001, 0, 1, 0);
    chk_state("lt_hz", 3'b001, 5, 4);
    for (int i = 0; i < 3; i++) begin
      step("ext_stall", 1, 1, 3'b011, 0, 1, 3'b111, 3'b110, 1, 0, 0);
      chk_state("ext_stall", 3'b001, 5, 4);
    end
    step("lt_release", 1, 1, 3'b011, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("lt_release", 3'b001, 6, 5);
    // Non-branch and flushed branch produce nothing.
    step("nonbr", 1, 0, 3'b111, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    step("flushed", 1, 1, 3'b111, 1, 0, 3'b000, 3'b000, 0, 0, 0);
    chk_state("flushed", 3'b001, 6, 5);
    // Flush arriving during HOLD drops the branch.
    step("eq_hz2", 1, 1, 3'b001, 0, 1, 3'b100, 3'b100, 0, 1, 0);
    chk_state("eq_hz2", 3'b101, 6, 5);
    step("hold_flush", 1, 1, 3'b001, 1, 0, 3'b000, 3'b000, 0, 0, 0);
    chk_state("hold_flush", 3'b101, 6, 5);
    step("after_flush", 1, 1, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("after_flush", 3'b101, 7, 6);

    // Drive the counters into saturation with back-to-back taken branches.
    id_valid = 1; id_is_branch = 1; id_ccc = 3'b111; id_flush = 0;
    ex_valid = 0; ex_flag_we = 0; ex_flags = 0; stall_ext = 0;
    repeat (65535) @(posedge clk);
    #1;
    chk_state("sat", 3'b101, 16'hFFFF, 16'hFFFF);
    step("sat_more", 1, 1, 3'b111, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("sat_more", 3'b101, 16'hFFFF, 16'hFFFF);

    // Reset asserted while in HOLD with the branch still in ID.
    step("rst_hz", 1, 1, 3'b001, 0, 1, 3'b111, 3'b111, 0, 1, 0);
    chk_state("rst_hz", 3'b111, 16'hFFFF, 16'hFFFF);
    ex_valid = 0;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid.stall_id", 32'(stall_id), 0);
    chk("rst_mid.take", 32'(take_branch), 0);
    chk("rst_mid.pc_sel", 32'(pc_sel), 0);
    chk_state("rst_mid", 3'b000, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_edge.take", 32'(take_branch), 0);
    rst_n = 1'b1;
    // Back in IDLE: NE with Z=0 resolves immediately.
    step("post_rst", 1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 1);
    chk_state("post_rst", 3'b000, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
